// File: rtl/dev_fsm_arbiter_pkg.sv
// Shared command-bit positions, arbiter state encoding and the read-command helper
// used by the dev_fsm arbiter and its round-robin sub-block.
package dev_fsm_arbiter_pkg;

  localparam int b_op_1   = 0;
  localparam int b_op_2   = 1;
  localparam int b_addop  = 2;
  localparam int b_addres = 3;
  localparam int b_tx     = 4;

  typedef enum logic [3:0] {
    IDLE,
    WAIT_BUSY,
    CMD,
    OP1,
    OP2,
    RD_BUSY,
    RD_CMD,
    RD_WAIT,
    DONE
  } arb_state_t;

  // Command byte that asks the device to transmit its result.
  function automatic int unsigned rd_cmd_val();
    return 32'd1 << b_tx;
  endfunction

endpackage

// File: rtl/dev_fsm_arbiter_rr_arbiter.sv
// Round-robin requester picker: searches from the index after the last-served
// requester, wrapping, and remembers the winner when the owner accepts it.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IW   = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            adv,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            hit
);

  logic [IW-1:0] last;
  int            cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    hit   = 1'b0;
    cand  = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(last) + k) % NREQ;
      if (!hit && req[cand]) begin
        hit         = 1'b1;
        grant[cand] = 1'b1;
        idx         = IW'(cand);
      end
    end
  end

  // Resetting to the top index makes requester 0 the first one searched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last <= IW'(NREQ - 1);
    end else if (adv) begin
      last <= idx;
    end
  end

endmodule

// File: rtl/dev_fsm_arbiter.sv
// Shares one dev_fsm among NREQ requesters: latches a job, drives the cs/din
// command/operand/read sequence and returns the device result to the owner.
module dev_fsm_arbiter
  import dev_fsm_arbiter_pkg::*;
#(
  parameter int DW   = 8,
  parameter int NREQ = 2,
  parameter int TMO  = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ*DW-1:0] req_cmd,
  input  logic [NREQ*DW-1:0] req_op1,
  input  logic [NREQ*DW-1:0] req_op2,
  input  logic [NREQ-1:0]  req_rd,
  output logic [NREQ-1:0]  ack,
  output logic [NREQ-1:0]  rsp_valid,
  output logic             rsp_err,
  output logic [DW-1:0]    rsp_data,
  output logic             busy,
  output logic             dev_cs,
  output logic [DW-1:0]    dev_din,
  input  logic             dev_busy,
  input  logic             dev_drdy,
  input  logic [DW-1:0]    dev_dout
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TMO + 1);

  arb_state_t      state, nxt;
  logic [NREQ-1:0] grant;
  logic [IW-1:0]   gidx;
  logic            any_req;
  logic            adv;
  logic [DW-1:0]   cmd_r, op1_r, op2_r;
  logic            rd_r;
  logic [IW-1:0]   owner;
  logic [CW-1:0]   cnt;
  logic            tmo_hit;
  arb_state_t      post_wr;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .adv   (adv),
    .grant (grant),
    .idx   (gidx),
    .hit   (any_req)
  );

  // The counter is compared one short of TMO-1 so the timeout DONE lands
  // exactly TMO cycles after RD_CMD.
  assign tmo_hit = (cnt == CW'(TMO - 2));
  assign busy    = (state != IDLE);
  assign post_wr = rd_r ? RD_BUSY : DONE;

  always_comb begin
    nxt       = state;
    adv       = 1'b0;
    ack       = '0;
    rsp_valid = '0;
    dev_cs    = 1'b0;
    dev_din   = '0;
    unique case (state)
      IDLE: begin
        if (any_req && rst) begin
          adv = 1'b1;
          ack = grant;
          nxt = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (!dev_busy) begin
          if (cmd_r != '0)  nxt = CMD;
          else if (rd_r)    nxt = RD_BUSY;
          else              nxt = DONE;
        end
      end
      CMD: begin
        dev_cs  = 1'b1;
        dev_din = cmd_r;
        if (cmd_r[b_op_1])      nxt = OP1;
        else if (cmd_r[b_op_2]) nxt = OP2;
        else                    nxt = post_wr;
      end
      OP1: begin
        dev_din = op1_r;
        nxt     = cmd_r[b_op_2] ? OP2 : post_wr;
      end
      OP2: begin
        dev_din = op2_r;
        nxt     = post_wr;
      end
      RD_BUSY: begin
        if (!dev_busy) nxt = RD_CMD;
      end
      RD_CMD: begin
        dev_cs  = 1'b1;
        dev_din = DW'(rd_cmd_val());
        nxt     = RD_WAIT;
      end
      RD_WAIT: begin
        if (dev_drdy || tmo_hit) nxt = DONE;
      end
      DONE: begin
        rsp_valid[owner] = 1'b1;
        nxt              = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cmd_r    <= '0;
      op1_r    <= '0;
      op2_r    <= '0;
      rd_r     <= 1'b0;
      owner    <= '0;
      cnt      <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      state <= nxt;
      if (adv) begin
        cmd_r <= req_cmd[int'(gidx)*DW +: DW];
        op1_r <= req_op1[int'(gidx)*DW +: DW];
        op2_r <= req_op2[int'(gidx)*DW +: DW];
        rd_r  <= req_rd[gidx];
        owner <= gidx;
      end
      if (state == RD_CMD)       cnt <= '0;
      else if (state == RD_WAIT) cnt <= cnt + CW'(1);
      // Result registers change only on entry to DONE and hold afterwards.
      if (nxt == DONE) begin
        if (state == RD_WAIT && dev_drdy) begin
          rsp_data <= dev_dout;
          rsp_err  <= 1'b0;
        end else if (state == RD_WAIT) begin
          rsp_data <= '0;
          rsp_err  <= 1'b1;
        end else begin
          rsp_data <= '0;
          rsp_err  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_dev_fsm_arbiter.sv
// Bench for dev_fsm_arbiter: a per-job expected cycle trace built from the job
// fields plays the device side and checks every output cycle by cycle.
module tb_dev_fsm_arbiter;
  import dev_fsm_arbiter_pkg::*;

  localparam int DW   = 8;
  localparam int NREQ = 2;
  localparam int TMO  = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic [NREQ-1:0]     req, req_rd, ack, rsp_valid;
  logic [NREQ*DW-1:0]  req_cmd, req_op1, req_op2;
  logic                rsp_err, busy, dev_cs, dev_busy, dev_drdy;
  logic [DW-1:0]       rsp_data, dev_din, dev_dout;

  dev_fsm_arbiter #(.DW(DW), .NREQ(NREQ), .TMO(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_cmd   (req_cmd),
    .req_op1   (req_op1),
    .req_op2   (req_op2),
    .req_rd    (req_rd),
    .ack       (ack),
    .rsp_valid (rsp_valid),
    .rsp_err   (rsp_err),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .dev_cs    (dev_cs),
    .dev_din   (dev_din),
    .dev_busy  (dev_busy),
    .dev_drdy  (dev_drdy),
    .dev_dout  (dev_dout)
  );

  // One entry per clock of a job: expected cs/din plus the device inputs to apply.
  typedef struct {
    logic          cs;
    logic [DW-1:0] din;
    logic          bsy;
    logic          drdy;
  } cyc_t;

  cyc_t          tr[$];
  int            total = 0;
  int            bad   = 0;
  int            last_srv, jidx, owner, drop_g;
  bit            active, rand_on;
  logic [DW-1:0] exp_data;
  logic          exp_err;

  logic [DW-1:0] j_cmd[NREQ], j_op1[NREQ], j_op2[NREQ], dout_r[NREQ];
  bit            j_rd[NREQ], stg[NREQ];
  int            nb_r[NREQ], nb2_r[NREQ], w_r[NREQ];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic cyc_t mk(input logic cs, input logic [DW-1:0] din,
                              input logic bsy, input logic drdy);
    cyc_t e;
    e.cs = cs; e.din = din; e.bsy = bsy; e.drdy = drdy;
    return e;
  endfunction

  task automatic set_job(input int i, input logic [DW-1:0] c, input logic [DW-1:0] o1,
                         input logic [DW-1:0] o2, input bit rd, input int nb, input int nb2,
                         input int w, input logic [DW-1:0] d);
    j_cmd[i] = c; j_op1[i] = o1; j_op2[i] = o2; j_rd[i] = rd;
    nb_r[i] = nb; nb2_r[i] = nb2; w_r[i] = w; dout_r[i] = d;
    stg[i] = 1'b1;
  endtask

  task automatic rand_job(input int i);
    int r;
    j_cmd[i]  = ($urandom_range(0, 5) == 0) ? '0 : DW'($urandom);
    j_op1[i]  = DW'($urandom);
    j_op2[i]  = DW'($urandom);
    j_rd[i]   = 1'($urandom_range(0, 1));
    nb_r[i]   = $urandom_range(0, 3);
    nb2_r[i]  = $urandom_range(0, 3);
    dout_r[i] = DW'($urandom);
    r = $urandom_range(0, 9);
    if (r == 0)      w_r[i] = TMO + 5;
    else if (r == 1) w_r[i] = TMO - 2;
    else             w_r[i] = $urandom_range(0, 5);
  endtask

  // Expected job from the spec rules: busy wait, cmd, chosen operands, optional read, done.
  function automatic void build(input int g);
    logic [DW-1:0] c;
    logic [DW-1:0] rdc;
    c   = j_cmd[g];
    rdc = DW'(1 << b_tx);
    tr.delete();
    tr.push_back(mk(1'b0, '0, 1'b0, 1'b0));
    repeat (nb_r[g]) tr.push_back(mk(1'b0, '0, 1'b1, 1'b0));
    tr.push_back(mk(1'b0, '0, 1'b0, 1'b0));
    if (c != '0) begin
      tr.push_back(mk(1'b1, c, 1'b0, 1'b0));
      if (c[b_op_1]) tr.push_back(mk(1'b0, j_op1[g], 1'b0, 1'b0));
      if (c[b_op_2]) tr.push_back(mk(1'b0, j_op2[g], 1'b0, 1'b0));
    end
    exp_data = '0;
    exp_err  = 1'b0;
    if (j_rd[g]) begin
      repeat (nb2_r[g]) tr.push_back(mk(1'b0, '0, 1'b1, 1'b0));
      tr.push_back(mk(1'b0, '0, 1'b0, 1'b0));
      tr.push_back(mk(1'b1, rdc, 1'b0, 1'b0));
      if (w_r[g] <= TMO - 2) begin
        repeat (w_r[g]) tr.push_back(mk(1'b0, '0, 1'b0, 1'b0));
        tr.push_back(mk(1'b0, '0, 1'b0, 1'b1));
        exp_data = dout_r[g];
      end else begin
        repeat (TMO - 1) tr.push_back(mk(1'b0, '0, 1'b0, 1'b0));
        exp_err = 1'b1;
      end
    end
    tr.push_back(mk(1'b0, '0, 1'b0, 1'b0));
    owner = g;
  endfunction

  task automatic drive_cycle();
    if (drop_g >= 0) begin
      req[drop_g] = 1'b0;
      drop_g = -1;
    end
    for (int i = 0; i < NREQ; i++) begin
      if (stg[i]) begin
        req[i] = 1'b1;
        stg[i] = 1'b0;
      end else if (rand_on && !req[i] && $urandom_range(0, 3) == 0) begin
        rand_job(i);
        req[i] = 1'b1;
      end else if (rand_on && req[i] && $urandom_range(0, 19) == 0) begin
        req[i] = 1'b0;
      end
      req_cmd[i*DW +: DW] = j_cmd[i];
      req_op1[i*DW +: DW] = j_op1[i];
      req_op2[i*DW +: DW] = j_op2[i];
      req_rd[i]           = j_rd[i];
    end
    if (active) begin
      dev_busy = tr[jidx].bsy;
      dev_drdy = tr[jidx].drdy;
      dev_dout = tr[jidx].drdy ? exp_data : DW'($urandom);
    end else begin
      dev_busy = 1'($urandom_range(0, 1));
      dev_drdy = 1'b0;
      dev_dout = '0;
    end
  endtask

  task automatic check_cycle();
    logic [NREQ-1:0] ea;
    logic [NREQ-1:0] ev;
    int              g;
    bit              done;
    cyc_t            e;
    if (!active) begin
      ea = '0;
      g  = -1;
      for (int k = 1; k <= NREQ; k++) begin
        int c;
        c = (last_srv + k) % NREQ;
        if (g < 0 && req[c]) g = c;
      end
      if (g >= 0) ea[g] = 1'b1;
      chk("ack", ack, ea);
      chk("busy_idle", busy, 0);
      chk("dev_idle", {dev_cs, dev_din}, 0);
      chk("rsp_valid_idle", rsp_valid, 0);
      if (g >= 0) begin
        build(g);
        last_srv = g;
        active   = 1'b1;
        jidx     = 1;
        drop_g   = g;
      end
    end else begin
      e    = tr[jidx];
      done = (jidx == tr.size() - 1);
      ev   = '0;
      if (done) ev[owner] = 1'b1;
      chk("dev_cs_din", {dev_cs, dev_din}, {e.cs, e.din});
      chk("ack_in_job", ack, 0);
      chk("busy", busy, 1);
      chk("rsp_valid", rsp_valid, ev);
      if (done) begin
        chk("rsp_err", rsp_err, exp_err);
        chk("rsp_data", rsp_data, exp_data);
        active = 1'b0;
      end
      jidx++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive_cycle();
    @(negedge clk);
    check_cycle();
  endtask

  task automatic settle(input int max);
    int n;
    bit pend;
    n = 0;
    pend = 1'b1;
    while (pend && n < max) begin
      step();
      n++;
      pend = active || (req != '0);
      for (int i = 0; i < NREQ; i++) if (stg[i]) pend = 1'b1;
    end
    chk("settle_bound", pend, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ack"}, ack, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_err"}, rsp_err, 0);
    chk({tag, "_rsp_data"}, rsp_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_dev"}, {dev_cs, dev_din}, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst = 1'b0; req = '0; req_rd = '0; req_cmd = '0; req_op1 = '0; req_op2 = '0;
    dev_busy = 1'b0; dev_drdy = 1'b0; dev_dout = '0;
    last_srv = NREQ - 1; active = 1'b0; drop_g = -1; rand_on = 1'b0;
    jidx = 0; owner = 0; exp_data = '0; exp_err = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      j_cmd[i] = '0; j_op1[i] = '0; j_op2[i] = '0; j_rd[i] = 1'b0; dout_r[i] = '0;
      nb_r[i] = 0; nb2_r[i] = 0; w_r[i] = 0; stg[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1; rst = 1'b1; drive_cycle(); @(negedge clk); check_cycle();

    // simultaneous pair straight after reset, then a second pair
    set_job(0, 8'h03, 8'h01, 8'h02, 1'b0, 0, 0, 0, 8'h00);
    set_job(1, 8'h01, 8'h0A, 8'h0B, 1'b1, 1, 0, 1, 8'h9C);
    settle(300);
    set_job(0, 8'h02, 8'h00, 8'hEE, 1'b1, 0, 2, 0, 8'h3C);
    set_job(1, 8'h07, 8'h44, 8'h55, 1'b0, 0, 0, 0, 8'h00);
    settle(300);

    // full write + read job with drdy result 8'h46
    set_job(0, 8'h07, 8'h12, 8'h34, 1'b1, 0, 0, 2, 8'h46);
    settle(200);
    // device busy for 5 cycles at job start
    set_job(0, 8'h07, 8'h21, 8'h43, 1'b0, 5, 0, 0, 8'h00);
    settle(200);
    // single operand then read
    set_job(1, 8'h09, 8'h05, 8'hFF, 1'b1, 0, 1, 0, 8'hC3);
    settle(200);
    // drdy never arrives: timeout, then a normal job
    set_job(0, 8'h01, 8'h77, 8'h00, 1'b1, 0, 0, TMO + 10, 8'h00);
    settle(300);
    set_job(1, 8'h03, 8'h10, 8'h20, 1'b1, 0, 0, 0, 8'h5A);
    settle(200);
    // drdy on the last counted cycle wins over the timeout
    set_job(0, 8'h00, 8'h00, 8'h00, 1'b1, 0, 0, TMO - 2, 8'hB7);
    settle(300);
    // empty job: no device traffic, zero result
    set_job(1, 8'h00, 8'h99, 8'h88, 1'b0, 2, 0, 0, 8'h00);
    settle(100);

    // reset during OP1 of a requester-1 job
    set_job(1, 8'h03, 8'hA5, 8'h5A, 1'b1, 0, 0, 1, 8'h77);
    n = 0;
    while (!(active && owner == 1 && jidx == 3) && n < 50) begin
      step();
      n++;
    end
    chk("reach_op1", (active && owner == 1 && jidx == 3), 1);
    @(posedge clk); #1; drive_cycle(); #1;
    chk("op1_pre_rst", {dev_cs, dev_din}, {1'b0, 8'hA5});
    rst = 1'b0;
    #1;
    chk_all_zero("mid_rst");
    active = 1'b0; tr.delete(); last_srv = NREQ - 1; drop_g = -1; req = '0;
    repeat (3) begin
      @(negedge clk);
      chk("rsp_valid_in_rst", rsp_valid, 0);
      chk("busy_in_rst", busy, 0);
    end
    set_job(1, 8'h03, 8'h11, 8'h22, 1'b0, 0, 0, 0, 8'h00);
    @(posedge clk); #1; rst = 1'b1; drive_cycle(); @(negedge clk); check_cycle();
    settle(200);

    // randomized traffic from both requesters
    rand_on = 1'b1;
    repeat (3000) step();
    rand_on = 1'b0;
    settle(800);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
